// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants for the multi-slope ADC sequencer
//
// Purpose: state encodings, analog mux switch codes and the default counter
// width used by adc_multislope_seq and its helpers.
// Ports: none (package).

package adc_pkg;

  localparam int CNT_W_DEF = 24;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHORT   = 3'd1;
  localparam logic [2:0] ST_RUNUP   = 3'd2;
  localparam logic [2:0] ST_RUNDOWN = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Integrator input switches, bit order {SIG, N, P}
  localparam logic [2:0] MUX_OFF = 3'b000;
  localparam logic [2:0] MUX_P   = 3'b001;
  localparam logic [2:0] MUX_N   = 3'b010;
  localparam logic [2:0] MUX_SIG = 3'b100;

  // Run-up switch setting: signal plus the reference that opposes the
  // integrator drift seen by the comparator.
  function automatic logic [2:0] runup_mux(input logic i_neg);
    return MUX_SIG | (i_neg ? MUX_N : MUX_P);
  endfunction

endpackage

// File: rtl/cmpr_sync.sv
// rtl/cmpr_sync.sv - two-flop synchroniser with edge detect for async inputs
//
// Purpose: brings an asynchronous level into the clk domain and flags its
// rising and falling edges. Edge flags lag the pin by two clocks and are
// combinational from the last two flops, so a registered consumer acts on
// the third clock.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   i_async    asynchronous input
//   o_level    synchronised level
//   o_rise     one-clock pulse on a synchronised rising edge
//   o_fall     one-clock pulse on a synchronised falling edge

module cmpr_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/adc_multislope_seq.sv
// rtl/adc_multislope_seq.sv - multi-slope integrating ADC conversion sequencer
//
// Purpose: shorts the integrator, runs fixed-length run-up phases steering the
// reference by the comparator, times a single-slope run-down to the comparator
// crossing, latches the counts and raises an interrupt.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   run               level; 1 keeps converting, 0 stops after current one
//   cfg_*             short length, phase length, force-P clock, phase count
//   cmpr_in           asynchronous comparator output
//   mux               {SIG, N, P} switch controls
//   int_short         integrator reset switch
//   cmpr_latch        comparator latch enable (0 = transparent)
//   res_*             latched results; res_valid pulses one clock
//   irq_n             active-low interrupt, held IRQ_CLKS clocks

module adc_multislope_seq
  import adc_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter int               IRQ_CLKS   = 16,
  parameter logic [CNT_W-1:0] RD_TIMEOUT = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] cfg_short_clks,
  input  logic [CNT_W-1:0] cfg_phase_clks,
  input  logic [CNT_W-1:0] cfg_fix_clks,
  input  logic [CNT_W-1:0] cfg_phases,
  input  logic             cmpr_in,
  output logic [2:0]       mux,
  output logic             int_short,
  output logic             cmpr_latch,
  output logic [CNT_W-1:0] res_up,
  output logic [CNT_W-1:0] res_down,
  output logic [CNT_W-1:0] res_rundown,
  output logic             res_dir,
  output logic             res_err,
  output logic             res_valid,
  output logic             irq_n
);

  localparam int               IRQ_W    = $clog2(IRQ_CLKS) + 1;
  localparam logic [IRQ_W-1:0] IRQ_LAST = IRQ_W'(IRQ_CLKS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       r_mux;
  logic             r_int_short;
  logic             r_cmpr_latch;
  logic             r_irq_n;
  logic             r_valid;
  logic [IRQ_W-1:0] r_irq_cnt;

  // Shadow copies of the configuration, frozen for one conversion
  logic [CNT_W-1:0] r_sh_short;
  logic [CNT_W-1:0] r_sh_phase_clks;
  logic [CNT_W-1:0] r_sh_fix;
  logic [CNT_W-1:0] r_sh_phases;

  logic [CNT_W-1:0] r_cnt;      // short clock or phase clock
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_up;
  logic [CNT_W-1:0] r_down;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_dir;

  logic [CNT_W-1:0] r_res_up;
  logic [CNT_W-1:0] r_res_down;
  logic [CNT_W-1:0] r_res_rundown;
  logic             r_res_dir;
  logic             r_res_err;

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_start;
  logic [CNT_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_phase_next;

  cmpr_sync u_cmpr_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (cmpr_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge       = w_rise | w_fall;
  assign w_rd_next    = r_rd_cnt + ONE;
  assign w_phase_next = r_phase + ONE;

  // A new conversion begins from IDLE, or straight out of DONE once the
  // interrupt window has elapsed, whenever run is high.
  assign w_start = run & ((r_state == ST_IDLE) |
                          ((r_state == ST_DONE) & (r_irq_cnt == IRQ_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_mux           <= MUX_OFF;
      r_int_short     <= 1'b0;
      r_cmpr_latch    <= 1'b1;
      r_irq_n         <= 1'b1;
      r_valid         <= 1'b0;
      r_irq_cnt       <= '0;
      r_sh_short      <= '0;
      r_sh_phase_clks <= '0;
      r_sh_fix        <= '0;
      r_sh_phases     <= '0;
      r_cnt           <= '0;
      r_phase         <= '0;
      r_up            <= '0;
      r_down          <= '0;
      r_rd_cnt        <= '0;
      r_dir           <= 1'b0;
      r_res_up        <= '0;
      r_res_down      <= '0;
      r_res_rundown   <= '0;
      r_res_dir       <= 1'b0;
      r_res_err       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: ;
        ST_SHORT: begin
          if (r_cnt == r_sh_short - ONE) begin
            r_state     <= ST_RUNUP;
            r_int_short <= 1'b0;
            r_mux       <= MUX_SIG | MUX_P;
            r_cnt       <= '0;
            r_phase     <= '0;
            r_up        <= '0;
            r_down      <= '0;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        ST_RUNUP: begin
          if (r_cnt == r_sh_phase_clks - ONE) begin
            r_cnt   <= '0;
            r_phase <= w_phase_next;
            if (w_level) r_up   <= r_up + ONE;
            else         r_down <= r_down + ONE;
            if (w_phase_next == r_sh_phases) begin
              // Signal disconnects; the last sample picks the run-down reference
              r_state  <= ST_RUNDOWN;
              r_mux    <= w_level ? MUX_N : MUX_P;
              r_dir    <= w_level;
              r_rd_cnt <= '0;
            end else begin
              r_mux <= runup_mux(w_level);
            end
          end else begin
            r_cnt <= r_cnt + ONE;
            if (r_cnt == r_sh_fix) r_mux <= MUX_SIG | MUX_P;
          end
        end
        ST_RUNDOWN: begin
          r_rd_cnt <= w_rd_next;
          // The count includes the synchroniser lag; a crossing on the
          // timeout clock still counts as a good conversion.
          if (w_edge || (w_rd_next == RD_TIMEOUT)) begin
            r_state       <= ST_DONE;
            r_mux         <= MUX_OFF;
            r_cmpr_latch  <= 1'b1;
            r_irq_n       <= 1'b0;
            r_irq_cnt     <= '0;
            r_valid       <= 1'b1;
            r_res_up      <= r_up;
            r_res_down    <= r_down;
            r_res_rundown <= w_rd_next;
            r_res_dir     <= r_dir;
            r_res_err     <= ~w_edge;
          end
        end
        ST_DONE: begin
          r_irq_cnt <= r_irq_cnt + 1'b1;
          if (r_irq_cnt == IRQ_LAST) begin
            r_irq_n <= 1'b1;
            if (!run) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_start) begin
        r_state         <= ST_SHORT;
        r_int_short     <= 1'b1;
        r_cmpr_latch    <= 1'b0;
        r_mux           <= MUX_OFF;
        r_cnt           <= '0;
        r_sh_short      <= cfg_short_clks;
        r_sh_phase_clks <= cfg_phase_clks;
        r_sh_fix        <= cfg_fix_clks;
        r_sh_phases     <= cfg_phases;
      end
    end
  end

  assign mux         = r_mux;
  assign int_short   = r_int_short;
  assign cmpr_latch  = r_cmpr_latch;
  assign irq_n       = r_irq_n;
  assign res_valid   = r_valid;
  assign res_up      = r_res_up;
  assign res_down    = r_res_down;
  assign res_rundown = r_res_rundown;
  assign res_dir     = r_res_dir;
  assign res_err     = r_res_err;

endmodule

// File: tb/tb_adc_multislope_seq.sv
// tb/tb_adc_multislope_seq.sv - self-checking bench for adc_multislope_seq

module tb_adc_multislope_seq;

  localparam int CNT_W    = 24;
  localparam int IRQ_CLKS = 16;
  localparam int RD_TMO   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic             cmpr_in;
  logic [CNT_W-1:0] cfg_short_clks;
  logic [CNT_W-1:0] cfg_phase_clks;
  logic [CNT_W-1:0] cfg_fix_clks;
  logic [CNT_W-1:0] cfg_phases;
  logic [2:0]       mux;
  logic             int_short;
  logic             cmpr_latch;
  logic [CNT_W-1:0] res_up;
  logic [CNT_W-1:0] res_down;
  logic [CNT_W-1:0] res_rundown;
  logic             res_dir;
  logic             res_err;
  logic             res_valid;
  logic             irq_n;

  int n_chk = 0;
  int n_err = 0;
  int nx_n, nx_p, nx_fix, nx_sc;

  adc_multislope_seq #(
    .CNT_W      (CNT_W),
    .IRQ_CLKS   (IRQ_CLKS),
    .RD_TIMEOUT (24'd100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .cfg_short_clks (cfg_short_clks),
    .cfg_phase_clks (cfg_phase_clks),
    .cfg_fix_clks   (cfg_fix_clks),
    .cfg_phases     (cfg_phases),
    .cmpr_in        (cmpr_in),
    .mux            (mux),
    .int_short      (int_short),
    .cmpr_latch     (cmpr_latch),
    .res_up         (res_up),
    .res_down       (res_down),
    .res_rundown    (res_rundown),
    .res_dir        (res_dir),
    .res_err        (res_err),
    .res_valid      (res_valid),
    .irq_n          (irq_n)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cfg();
    nx_n   = $urandom_range(1, 6);
    nx_p   = $urandom_range(4, 12);
    nx_fix = $urandom_range(0, nx_p - 1);
    nx_sc  = $urandom_range(1, 8);
  endtask

  // One conversion using the already-sampled config (n, p, fix, sc). The
  // comparator is held per phase; in run-down it flips d clocks after entry
  // unless tmo is set. The next config is presented during run-up.
  task automatic do_conv(input int n, input int p, input int fix, input int sc,
                         input int d, input bit tmo, input bit drop, input bit ones);
    int cnt;
    int ups;
    int exp_rd;
    bit b[$];
    cnt = 0;
    while (int_short !== 1'b1 && cnt < 50) begin tick(); cnt++; end
    check_val("short_start", int_short, 1);
    cnt = 0;
    while (int_short === 1'b1 && cnt < 100) begin tick(); cnt++; end
    check_val("short_len", cnt, sc);
    check_val("runup_entry_mux", mux, 3'b101);
    check_val("runup_latch", cmpr_latch, 0);
    cfg_short_clks = nx_sc;
    cfg_phase_clks = nx_p;
    cfg_fix_clks   = nx_fix;
    cfg_phases     = nx_n;
    ups = 0;
    for (int k = 0; k < n; k++) begin
      b.push_back(ones ? 1'b1 : 1'($urandom_range(0, 1)));
      ups += int'(b[k]);
    end
    cmpr_in = b[0];
    for (int k = 0; k < n; k++) begin
      for (int c = 1; c <= p; c++) begin
        tick();
        if (c == fix + 1 && c < p) check_val("fix_mux", mux, 3'b101);
        if (c == p) begin
          if (k < n - 1) begin
            check_val("phase_mux", mux, b[k] ? 3'b110 : 3'b101);
            cmpr_in = b[k+1];
          end else begin
            check_val("rundown_mux", mux, b[k] ? 3'b010 : 3'b001);
          end
        end
      end
    end
    if (drop) run = 1'b0;
    if (!tmo) begin
      repeat (d) tick();
      cmpr_in = ~b[n-1];
      cnt = d;
      exp_rd = d + 3;
    end else begin
      cnt = 0;
      exp_rd = RD_TMO;
    end
    while (res_valid !== 1'b1 && cnt < RD_TMO + 10) begin tick(); cnt++; end
    check_val("rd_latency", cnt, exp_rd);
    check_val("res_up", res_up, ups);
    check_val("res_down", res_down, n - ups);
    check_val("up_plus_down", res_up + res_down, n);
    check_val("res_dir", res_dir, b[n-1]);
    check_val("res_err", res_err, tmo);
    check_val("res_rundown", res_rundown, exp_rd);
    check_val("done_mux", mux, 3'b000);
    check_val("irq_fall", irq_n, 0);
    cnt = 0;
    do begin
      cnt++;
      tick();
      if (cnt == 1) check_val("valid_pulse", res_valid, 0);
    end while (irq_n === 1'b0 && cnt < 100);
    check_val("irq_len", cnt, IRQ_CLKS);
    check_val("post_int_short", int_short, !drop);
    check_val("post_latch", cmpr_latch, drop);
    check_val("res_hold", res_rundown, exp_rd);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    run = 1'b0;
    cmpr_in = 1'b0;
    cfg_short_clks = 24'd5;
    cfg_phase_clks = 24'd10;
    cfg_fix_clks   = 24'd8;
    cfg_phases     = 24'd4;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mux", mux, 0);
    check_val("rst_int_short", int_short, 0);
    check_val("rst_latch", cmpr_latch, 1);
    check_val("rst_irq", irq_n, 1);
    check_val("rst_valid", res_valid, 0);
    check_val("rst_up", res_up, 0);
    check_val("rst_down", res_down, 0);
    check_val("rst_rundown", res_rundown, 0);
    check_val("rst_dir", res_dir, 0);
    check_val("rst_err", res_err, 0);

    // Asynchronous reset in the middle of run-up
    rst = 1'b0;
    run = 1'b1;
    cnt = 0;
    while (mux !== 3'b101 && cnt < 50) begin tick(); cnt++; end
    check_val("reach_runup", mux, 3'b101);
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    check_val("arst_mux", mux, 0);
    check_val("arst_irq", irq_n, 1);
    check_val("arst_int_short", int_short, 0);
    check_val("arst_latch", cmpr_latch, 1);
    check_val("arst_up", res_up, 0);
    check_val("arst_rundown", res_rundown, 0);
    run = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check_val("idle_int_short", int_short, 0);
    check_val("idle_mux", mux, 0);

    // Directed: comparator high all run-up, crossing 37 clocks into run-down
    nx_n = 3; nx_p = 6; nx_fix = 2; nx_sc = 3;
    run = 1'b1;
    do_conv(4, 10, 8, 5, 37, 1'b0, 1'b0, 1'b1);

    // Directed timeout, back to back; then randomized back-to-back runs
    begin
      int c_n, c_p, c_fix, c_sc;
      c_n = nx_n; c_p = nx_p; c_fix = nx_fix; c_sc = nx_sc;
      rand_cfg();
      do_conv(c_n, c_p, c_fix, c_sc, 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
        c_n = nx_n; c_p = nx_p; c_fix = nx_fix; c_sc = nx_sc;
        rand_cfg();
        do_conv(c_n, c_p, c_fix, c_sc, $urandom_range(1, 90), 1'b0, (i == 5), 1'b0);
      end
    end

    repeat (5) tick();
    check_val("final_idle_short", int_short, 0);
    check_val("final_idle_latch", cmpr_latch, 1);
    check_val("final_idle_mux", mux, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
